// File: rtl/panel_joy.sv
// DE2 panel controls to two MiSTer-style joystick words: synchronise, debounce,
// optional SOCD cleaning, then register the outputs with a change strobe.
module panel_joy #(
    parameter int DEB_CYCLES = 250000,
    parameter bit SOCD_CLEAN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] sw,
    input  logic [3:0]  key_n,
    output logic [31:0] joystick_0,
    output logic [31:0] joystick_1,
    output logic        reset_req,
    output logic        gpads_enable,
    output logic        joy_changed
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEB_CYCLES - 1);

    // Bit order inside each player byte matches the joystick word layout.
    logic [7:0]  raw_p1;
    logic [7:0]  raw_p2;
    logic [17:0] raw;
    logic        unused_sw;

    assign raw_p1 = {~key_n[3], sw[4], sw[5], ~key_n[2], sw[2], sw[1], sw[3], sw[0]};
    assign raw_p2 = {~key_n[1], sw[11], sw[12], ~key_n[0], sw[9], sw[8], sw[10], sw[7]};
    assign raw    = {sw[16], sw[15], raw_p2, raw_p1};
    assign unused_sw = ^{sw[17], sw[14:13], sw[6]};

    logic [17:0] sync1_reg;
    logic [17:0] sync2_reg;
    logic [17:0] stable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 18; gi++) begin : g_deb
            logic [CW-1:0] cnt_reg;
            logic          stable_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                end else if (sync2_reg[gi] == stable_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == LAST_COUNT) begin
                    stable_reg <= sync2_reg[gi];
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign stable[gi] = stable_reg;
        end
    endgenerate

    // Opposing directions cancel to neutral; only debounced bits are cleaned.
    function automatic logic [7:0] socd(input logic [7:0] p);
        logic [7:0] r;
        r = p;
        if (SOCD_CLEAN) begin
            if (p[0] && p[1]) r[1:0] = 2'b00;
            if (p[2] && p[3]) r[3:2] = 2'b00;
        end
        return r;
    endfunction

    logic [7:0] joy0_next;
    logic [7:0] joy1_next;
    logic [7:0] joy0_reg;
    logic [7:0] joy1_reg;
    logic       reset_req_reg;
    logic       gpads_reg;
    logic       changed_reg;

    assign joy0_next = socd(stable[7:0]);
    assign joy1_next = socd(stable[15:8]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            joy0_reg      <= '0;
            joy1_reg      <= '0;
            reset_req_reg <= 1'b0;
            gpads_reg     <= 1'b0;
            changed_reg   <= 1'b0;
        end else begin
            joy0_reg      <= joy0_next;
            joy1_reg      <= joy1_next;
            reset_req_reg <= stable[17];
            gpads_reg     <= stable[16];
            // Strobe lines up with the clock in which the new words appear.
            changed_reg   <= (joy0_next != joy0_reg) || (joy1_next != joy1_reg);
        end
    end

    assign joystick_0   = {24'h0, joy0_reg};
    assign joystick_1   = {24'h0, joy1_reg};
    assign reset_req    = reset_req_reg;
    assign gpads_enable = gpads_reg;
    assign joy_changed  = changed_reg;

endmodule

// File: tb/tb_panel_joy.sv
// Directed bench for panel_joy: expectations are queued with a due cycle when
// stimulus is applied and compared on the falling edge of that cycle.
module tb_panel_joy;

    logic        clk;
    logic        reset;
    logic [17:0] sw;
    logic [3:0]  key_n;

    logic [31:0] m_j0, m_j1, s_j0, s_j1, f_j0, f_j1;
    logic        m_rr, m_ge, m_chg, s_rr, s_ge, s_chg, f_rr, f_ge, f_chg;

    panel_joy #(.DEB_CYCLES(4), .SOCD_CLEAN(1'b1)) u_main (
        .clk(clk), .reset(reset), .sw(sw), .key_n(key_n),
        .joystick_0(m_j0), .joystick_1(m_j1), .reset_req(m_rr),
        .gpads_enable(m_ge), .joy_changed(m_chg));

    panel_joy #(.DEB_CYCLES(4), .SOCD_CLEAN(1'b0)) u_nosocd (
        .clk(clk), .reset(reset), .sw(sw), .key_n(key_n),
        .joystick_0(s_j0), .joystick_1(s_j1), .reset_req(s_rr),
        .gpads_enable(s_ge), .joy_changed(s_chg));

    panel_joy #(.DEB_CYCLES(1), .SOCD_CLEAN(1'b1)) u_fast (
        .clk(clk), .reset(reset), .sw(sw), .key_n(key_n),
        .joystick_0(f_j0), .joystick_1(f_j1), .reset_req(f_rr),
        .gpads_enable(f_ge), .joy_changed(f_chg));

    localparam int J0 = 0, J1 = 1, RR = 2, GE = 3, CHG = 4, J0S = 5, J1F = 6;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] v;
        string       tag;
    } entry_t;

    entry_t q[$];
    int     cyc = 0;
    int     n_assert = 0;
    int     n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(input int s);
        case (s)
            J0:      return m_j0;
            J1:      return m_j1;
            RR:      return {31'h0, m_rr};
            GE:      return {31'h0, m_ge};
            CHG:     return {31'h0, m_chg};
            J0S:     return s_j0;
            J1F:     return f_j1;
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, want, cyc);
        end
    endtask

    task automatic expect_at(input int dly, input int s, input logic [31:0] v, input string tag);
        entry_t e;
        int     i;
        e.due = cyc + dly;
        e.sel = s;
        e.v   = v;
        e.tag = tag;
        i = 0;
        while (i < q.size() && q[i].due <= e.due) i++;
        q.insert(i, e);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            entry_t e;
            e = q.pop_front();
            if (e.due < cyc) begin
                chk({e.tag, "_stale"}, 32'(e.due), 32'(cyc));
            end else begin
                chk(e.tag, observe(e.sel), e.v);
                $display("cycle %0d %s observed %h expected %h", cyc, e.tag, observe(e.sel), e.v);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        sw    = '0;
        key_n = 4'hF;
        #2 reset = 1'b1;
        #1;
        chk("rst_j0", m_j0, 32'h0);
        chk("rst_j1", m_j1, 32'h0);
        chk("rst_rr", {31'h0, m_rr}, 32'h0);
        chk("rst_ge", {31'h0, m_ge}, 32'h0);
        chk("rst_chg", {31'h0, m_chg}, 32'h0);
        step(3);
        chk("rst_hold_j0", m_j0, 32'h0);
        reset = 1'b0;

        // Idle after release with keys up: nothing may appear.
        for (int k = 1; k <= 10; k++) begin
            expect_at(k, J0, 32'h0, "idle_j0");
            expect_at(k, J1, 32'h0, "idle_j1");
            expect_at(k, CHG, 32'h0, "idle_chg");
        end
        step(12);

        // SW[0] -> Right after exactly 7 edges, single strobe.
        sw[0] = 1'b1;
        expect_at(6, J0, 32'h00, "sw0_early");
        expect_at(6, CHG, 32'h0, "sw0_chg_early");
        expect_at(7, J0, 32'h01, "sw0_j0");
        expect_at(7, CHG, 32'h1, "sw0_chg");
        expect_at(8, CHG, 32'h0, "sw0_chg_end");
        step(10);

        // Start glitch of 3 clocks is rejected.
        key_n[3] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            expect_at(k, J0, 32'h01, "glitch_j0");
            expect_at(k, CHG, 32'h0, "glitch_chg");
        end
        step(3);
        key_n[3] = 1'b1;
        step(10);

        // Left + Right: cleaned to neutral, raw on the pass-through instance.
        sw[3] = 1'b1;
        expect_at(6, J0, 32'h01, "socd_early");
        expect_at(7, J0, 32'h00, "socd_j0");
        expect_at(7, CHG, 32'h1, "socd_chg");
        expect_at(8, CHG, 32'h0, "socd_chg_end");
        expect_at(6, J0S, 32'h01, "nosocd_early");
        expect_at(7, J0S, 32'h03, "nosocd_j0");
        step(10);

        sw[0] = 1'b0;
        sw[3] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            expect_at(k, J0, 32'h0, "socd_rel_j0");
            expect_at(k, CHG, 32'h0, "socd_rel_chg");
        end
        expect_at(6, J0S, 32'h03, "nosocd_rel_early");
        expect_at(7, J0S, 32'h00, "nosocd_rel_j0");
        step(10);

        // Reset request and pad enable never strobe joy_changed.
        sw[16] = 1'b1;
        sw[15] = 1'b1;
        expect_at(6, RR, 32'h0, "rr_early");
        expect_at(7, RR, 32'h1, "rr_set");
        expect_at(6, GE, 32'h0, "ge_early");
        expect_at(7, GE, 32'h1, "ge_set");
        for (int k = 1; k <= 10; k++) expect_at(k, CHG, 32'h0, "rr_chg");
        step(10);

        // Reset mid-debounce of SW[2]; a full count is needed after release.
        sw[2] = 1'b1;
        step(5);
        reset = 1'b1;
        #2;
        chk("mid_rst_j0", m_j0, 32'h0);
        chk("mid_rst_rr", {31'h0, m_rr}, 32'h0);
        chk("mid_rst_ge", {31'h0, m_ge}, 32'h0);
        chk("mid_rst_chg", {31'h0, m_chg}, 32'h0);
        step(2);
        reset = 1'b0;
        expect_at(6, J0, 32'h00, "post_rst_early");
        expect_at(7, J0, 32'h08, "post_rst_up");
        expect_at(7, CHG, 32'h1, "post_rst_chg");
        expect_at(6, RR, 32'h0, "post_rst_rr_early");
        expect_at(7, RR, 32'h1, "post_rst_rr");
        step(10);

        sw = '0;
        step(12);

        // Player 2: A, Start and Right together -> one strobe.
        key_n[1:0] = 2'b00;
        sw[7] = 1'b1;
        expect_at(6, J1, 32'h00, "p2_early");
        expect_at(7, J1, 32'h91, "p2_j1");
        expect_at(6, CHG, 32'h0, "p2_chg_early");
        expect_at(7, CHG, 32'h1, "p2_chg");
        expect_at(8, CHG, 32'h0, "p2_chg_end");
        expect_at(3, J1F, 32'h00, "fast_p2_early");
        expect_at(4, J1F, 32'h91, "fast_p2");
        step(10);

        // DEB_CYCLES = 1: SW[9] (Up) after 4 edges.
        sw[9] = 1'b1;
        expect_at(3, J1F, 32'h91, "fast_up_early");
        expect_at(4, J1F, 32'h99, "fast_up");
        expect_at(6, J1, 32'h91, "p2_up_early");
        expect_at(7, J1, 32'h99, "p2_up");
        step(10);

        if (q.size() != 0) chk("queue_drained", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/panel_joy.md
PANEL_JOY -- requirements
Module: panel_joy

Interface
REQ-001 Parameter DEB_CYCLES, default 250000, means the number of consecutive clocks a synchronised input must differ from its debounced state before it is accepted (5 ms at 50 MHz); legal range 1..2^20-1.
REQ-002 Parameter SOCD_CLEAN, default 1, means 1 cancels opposing directions and 0 passes them through.
REQ-003 clk  input  1  is the system clock (CLOCK_50 domain); one clock only.
REQ-004 reset  input  1  is an asynchronous, active-high reset.
REQ-005 sw  input  18  carries the raw toggle switches, active-high and asynchronous to clk.
REQ-006 key_n  input  4  carries the raw push buttons, active-low and asynchronous to clk.
REQ-007 joystick_0  output  32  is the player-1 word: bits [7:0] = {Start, C, B, A, Up, Down, Left, Right}; bits [31:8] = 0.
REQ-008 joystick_1  output  32  is the player-2 word, with the same layout as joystick_0.
REQ-009 reset_req  output  1  is debounced SW[16], the user reset request.
REQ-010 gpads_enable  output  1  is debounced SW[15], which enables the serial pads.
REQ-011 joy_changed  output  1  is a one-clock strobe that fires when joystick_0 or joystick_1 changes.

Function
REQ-012 Input mapping, player 1: R = SW[0], D = SW[1], U = SW[2], L = SW[3], C = SW[4], B = SW[5], A = ~KEY[2], Start = ~KEY[3].
REQ-013 Input mapping, player 2: R = SW[7], D = SW[8], U = SW[9], L = SW[10], C = SW[11], B = SW[12], A = ~KEY[0], Start = ~KEY[1].
REQ-014 Each of the 18 used inputs (16 pad bits plus SW[15] and SW[16]) passes through a 2-flop synchroniser after key polarity inversion; unused SW bits are ignored.
REQ-015 Each input has its own counter, wide enough for DEB_CYCLES, and one stable bit.
REQ-016 When the synchronised value equals the stable bit, the counter clears to 0.
REQ-017 When the synchronised value differs from the stable bit, the counter increments.
REQ-018 When the counter equals DEB_CYCLES-1 and the values still differ, the stable bit takes the synchronised value and the counter clears to 0.
REQ-019 A glitch lasting fewer than DEB_CYCLES clocks after synchronisation never reaches the stable bit, and its counter returns to 0 on the first matching clock.
REQ-020 With DEB_CYCLES = 1, the stable bit follows the synchroniser output with one clock of delay.
REQ-021 SOCD cleaning (SOCD_CLEAN = 1), per player: if stable L and R are both 1, the output L and R are both 0; if stable U and D are both 1, the output U and D are both 0.
REQ-022 SOCD cleaning is applied only after debouncing, never to raw inputs.
REQ-023 joystick_0, joystick_1, reset_req and gpads_enable are registered from the cleaned stable bits.
REQ-024 Latency from a clean input edge to the output is exactly DEB_CYCLES+3 clk edges: 2 synchroniser edges, DEB_CYCLES counting edges (the last of which updates the stable bit), and 1 output-register edge.
REQ-025 joy_changed is 1 for exactly the single clock in which the registered joystick_0 or joystick_1 differs from its value on the previous clock.
REQ-026 joy_changed does not fire when only reset_req or gpads_enable changes.
REQ-027 Simultaneous stable changes on several bits in the same clock produce one joy_changed pulse, not one per bit.
REQ-028 A counter never exceeds DEB_CYCLES-1 and never wraps.
REQ-029 No combinational path exists from any input to any output.

Reset
REQ-030 While reset is high, all synchroniser flops, stable bits, counters and output registers are 0, regardless of clk.
REQ-031 While reset is high, joystick_0 = joystick_1 = 32'h0, reset_req = 0, gpads_enable = 0 and joy_changed = 0.
REQ-032 Because a released key (key_n = 1) maps to stable 0, no spurious press or joy_changed pulse occurs after reset release when all keys are up.
REQ-033 A switch held on through reset release is accepted after DEB_CYCLES+3 edges.
REQ-034 Reset asserted mid-debounce clears that counter; after release, a fresh full DEB_CYCLES count is required.

Verification (DEB_CYCLES = 4 unless stated)
REQ-035 SW[0] 0->1 and held -> joystick_0 = 32'h01 exactly 7 clk edges later, with joy_changed high for exactly that one clock.
REQ-036 key_n[3] pulsed low for 3 clocks -> joystick_0[7] stays 0 and joy_changed stays 0.
REQ-037 SW[3] and SW[0] both set and held, SOCD_CLEAN = 1 -> joystick_0[1:0] = 2'b00; with SOCD_CLEAN = 0 -> 2'b11.
REQ-038 SW[16] set -> reset_req = 1 after 7 edges with no joy_changed; reset asserted after 5 edges of SW[2] held, then released -> joystick_0[3] = 1 only 7 edges after release.
REQ-039 key_n[0] and key_n[1] low and SW[7] high, all in the same clock -> joystick_1 = 32'h91 after 7 edges, with a single one-clock joy_changed pulse.
REQ-040 With DEB_CYCLES = 1, SW[9] set -> joystick_1[3] = 1 after 4 edges.
